// File: rtl/sfu_pkg.sv
// Shared constants and types for the SFU front-end blocks.
package sfu_pkg;

    localparam int SFU_DATA_W   = 32;
    localparam int EXP2_LATENCY = 6;
    localparam int SFU_NUM_REQ  = 4;

    localparam logic [SFU_DATA_W-1:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [SFU_DATA_W-1:0] FP32_INF  = 32'h7F80_0000;
    localparam logic [SFU_DATA_W-1:0] FP32_ZERO = 32'h0000_0000;

    typedef logic [$clog2(SFU_NUM_REQ)-1:0] sfu_tag_t;

endpackage

// File: rtl/sfu_exp2_arbiter_rr.sv
// Round-robin arbiter: searches upward from the requester after the last one
// accepted; the pointer only moves when the grant is actually taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx
);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] sel;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    // Reset to the last index so requester 0 has priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= TAG_W'(NUM_REQ - 1);
        end else if (advance) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/sfu_exp2_arbiter.sv
// Shares one pipelined 2^x unit among NUM_REQ requesters; a shadow valid/tag
// pipeline mirrors the unit so each result is routed to its issuer.
module sfu_exp2_arbiter
    import sfu_pkg::*;
#(
    parameter int NUM_REQ    = SFU_NUM_REQ,
    parameter int DATA_WIDTH = SFU_DATA_W,
    parameter int LATENCY    = EXP2_LATENCY,
    parameter int TAG_W      = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(LATENCY + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [DATA_WIDTH-1:0]         exp_operand,
    output logic                          exp_vld_in,
    output logic                          exp_en,
    input  logic [DATA_WIDTH-1:0]         exp_result,
    input  logic                          exp_vld_out,
    output logic                          busy,
    output logic [CNT_W-1:0]              inflight,
    output logic                          err
);

    logic [LATENCY-1:0] vld_sr;
    logic [TAG_W-1:0]   tag_sr [LATENCY];
    logic               head_vld;
    logic [TAG_W-1:0]   head_tag;
    logic               stall;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               rsp_hs;

    assign head_vld = vld_sr[LATENCY-1];
    assign head_tag = tag_sr[LATENCY-1];

    // A head result whose owner is not ready freezes the whole unit.
    assign stall      = head_vld & ~resp_ready[head_tag];
    assign exp_en     = ~stall;
    assign exp_vld_in = exp_en & (|req_valid);
    assign req_ready  = exp_en ? grant : '0;
    assign resp_data  = exp_result;
    assign rsp_hs     = |(resp_valid & resp_ready);
    assign busy       = (inflight != '0);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = head_vld && (head_tag == TAG_W'(i));
        end
    end

    always_comb begin
        exp_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                exp_operand = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (exp_vld_in),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_sr[k] <= '0;
            end
        end else if (exp_en) begin
            vld_sr    <= {vld_sr[LATENCY-2:0], exp_vld_in};
            tag_sr[0] <= grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                tag_sr[k] <= tag_sr[k-1];
            end
        end
    end

    // Counter overflow/underflow and unit/shadow disagreement are all fatal bookkeeping errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (exp_vld_in && !rsp_hs) begin
                if (inflight == CNT_W'(LATENCY)) begin
                    err <= 1'b1;
                end else begin
                    inflight <= inflight + CNT_W'(1);
                end
            end else if (!exp_vld_in && rsp_hs) begin
                if (inflight == '0) begin
                    err <= 1'b1;
                end else begin
                    inflight <= inflight - CNT_W'(1);
                end
            end
            if (exp_en && (exp_vld_out != head_vld)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sfu_exp2_arbiter.sv
// Bench for sfu_exp2_arbiter: a simple 2^x unit model plus an operation-level
// reference (queue of in-flight ops with ages) checked every cycle.
module tb_sfu_exp2_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 6;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   resp_data, exp_operand, exp_result;
    logic            exp_vld_in, exp_en, exp_vld_out, busy, err;
    logic [CW-1:0]   inflight;
    logic            force_vld;

    always #5 clk = ~clk;

    sfu_exp2_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .exp_operand (exp_operand),
        .exp_vld_in  (exp_vld_in),
        .exp_en      (exp_en),
        .exp_result  (exp_result),
        .exp_vld_out (exp_vld_out),
        .busy        (busy),
        .inflight    (inflight),
        .err         (err)
    );

    // Integer-exact 2^x reference with overflow to +inf and underflow flushed to zero.
    function automatic int int_of_fp32(input logic [31:0] x);
        int e, mag;
        if (x[30:0] == 31'd0) return 0;
        e = int'(x[30:23]) - 127;
        if (e < 0) mag = 0;
        else if (e > 29) mag = 1 << 30;
        else if (e >= 23) mag = int'({1'b1, x[22:0]}) << (e - 23);
        else mag = int'({1'b1, x[22:0]}) >> (23 - e);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] fp32_of_int(input int n);
        int m, p, mant;
        if (n == 0) return 32'h0;
        m = (n < 0) ? -n : n;
        p = 0;
        for (int b = 0; b < 31; b++) if (((m >> b) & 1) == 1) p = b;
        mant = (m << (23 - p)) & 32'h7F_FFFF;
        return {n < 0, 8'(127 + p), 23'(mant)};
    endfunction

    function automatic logic [31:0] exp2_model(input logic [31:0] x);
        int n;
        n = int_of_fp32(x);
        if (n >= 128) return 32'h7F80_0000;
        if (n <= -127) return 32'h0;
        return {1'b0, 8'(n + 127), 23'd0};
    endfunction

    // Stand-in for the pipelined unit: frozen while en is low, cleared by rst.
    logic [L-1:0] u_vld;
    logic [31:0]  u_dat [L];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_vld <= '0;
        end else if (exp_en) begin
            u_vld    <= {u_vld[L-2:0], exp_vld_in};
            u_dat[0] <= exp_operand;
            for (int k = 1; k < L; k++) u_dat[k] <= u_dat[k-1];
        end
    end
    assign exp_vld_out = u_vld[L-1] | force_vld;
    assign exp_result  = exp2_model(u_dat[L-1]);

    int          total = 0, bad = 0;
    int          age_q[$];
    int          tag_q[$];
    logic [31:0] res_q[$];
    int          last_g = N - 1;
    int          cnt = 0, peak = 0, cyc = 0, acc_cyc = 0, hs_cyc = 0;
    bit          err_exp = 1'b0;
    logic [N-1:0] acc_mask = '0;
    int          grant_log[$];
    logic [31:0] resp_log [N][$];
    logic [31:0] pend_q [N][$];
    logic [31:0] exp_seq [N][$];
    bit          rand_ready = 1'b0, rand_gap = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin : mon
        bit           hv, en_m, hs;
        int           ht, gi, idx;
        logic [N-1:0] exp_rv, exp_rr;
        logic [31:0]  op;
        cyc++;
        if (rst) begin
            age_q.delete(); tag_q.delete(); res_q.delete();
            cnt = 0; last_g = N - 1; err_exp = 1'b0; acc_mask = '0;
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_inflight", 32'(inflight), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_exp_en", 32'(exp_en), 1);
        end else begin
            hv = (age_q.size() > 0) && (age_q[0] == L);
            ht = hv ? tag_q[0] : 0;
            exp_rv = '0;
            if (hv) exp_rv[ht] = 1'b1;
            en_m = !(hv && !resp_ready[ht]);
            gi = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (last_g + k) % N;
                if (gi < 0 && req_valid[idx]) gi = idx;
            end
            exp_rr = '0;
            op = 32'h0;
            if (gi >= 0) begin
                op = req_data[gi*DW +: DW];
                if (en_m) exp_rr[gi] = 1'b1;
            end
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("exp_en", 32'(exp_en), 32'(en_m));
            chk("req_ready", 32'(req_ready), 32'(exp_rr));
            chk("exp_vld_in", 32'(exp_vld_in), 32'(en_m && gi >= 0));
            chk("exp_operand", exp_operand, op);
            chk("inflight", 32'(inflight), cnt);
            chk("busy", 32'(busy), 32'(cnt != 0));
            chk("err", 32'(err), 32'(err_exp));
            if (hv) chk("resp_data", resp_data, res_q[0]);
            if (en_m && (exp_vld_out != hv)) err_exp = 1'b1;
            hs = hv && resp_ready[ht];
            acc_mask = exp_rr & req_valid;
            if (hs) begin
                resp_log[ht].push_back(res_q[0]);
                hs_cyc = cyc;
                void'(age_q.pop_front()); void'(tag_q.pop_front()); void'(res_q.pop_front());
                cnt--;
            end
            if (en_m) begin
                foreach (age_q[j]) age_q[j]++;
                if (gi >= 0) begin
                    age_q.push_back(1); tag_q.push_back(gi); res_q.push_back(exp2_model(op));
                    grant_log.push_back(gi);
                    last_g = gi; acc_cyc = cyc; cnt++;
                end
            end
            if (cnt > peak) peak = cnt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && pend_q[i].size() > 0 && !rst &&
                (!rand_gap || $urandom_range(0, 2) != 0)) begin
                req_data[i*DW +: DW] = pend_q[i].pop_front();
                req_valid[i] = 1'b1;
            end
        end
        if (rand_ready) for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bit idle();
        for (int i = 0; i < N; i++) if (pend_q[i].size() > 0) return 1'b0;
        return (req_valid == '0) && (age_q.size() == 0);
    endfunction

    task automatic wait_idle(input int maxc, input string nm);
        int c;
        c = 0;
        while (!idle() && c < maxc) begin step(); c++; end
        if (!idle()) begin
            total++; bad++;
            $display("FAIL %s timeout after %0d cycles", nm, maxc);
        end
        step();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        for (int i = 0; i < N; i++) begin resp_log[i].delete(); exp_seq[i].delete(); end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) pend_q[i].delete();
        step(); step();
        rst = 1'b0;
        step();
        clear_logs();
    endtask

    int seq_bad, lim;
    logic [31:0] d;
    int exp_g [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = '1; force_vld = 1'b0;
        chk("pin_exp2_one", exp2_model(32'h3F80_0000), 32'h4000_0000);
        chk("pin_exp2_m1", exp2_model(32'hBF80_0000), 32'h3F00_0000);
        chk("pin_exp2_hi", exp2_model(32'h4300_0000), 32'h7F80_0000);
        chk("pin_exp2_lo", exp2_model(32'hC300_0000), 32'h0);
        chk("pin_fp_m128", fp32_of_int(-128), 32'hC300_0000);
        repeat (3) step();
        rst = 1'b0;
        step();

        // single op
        clear_logs();
        pend_q[0].push_back(32'h3F80_0000);
        wait_idle(100, "single");
        chk("single_latency", hs_cyc - acc_cyc, 6);
        chk("single_count", resp_log[0].size(), 1);
        chk("single_data", resp_log[0].size() > 0 ? resp_log[0][0] : 32'hDEAD_BEEF, 32'h4000_0000);
        chk("single_inflight", 32'(inflight), 0);

        // round robin from a fresh reset
        do_reset();
        pend_q[0].push_back(32'h0); pend_q[0].push_back(32'h0);
        pend_q[1].push_back(32'h3F80_0000);
        pend_q[2].push_back(32'hBF80_0000);
        pend_q[3].push_back(32'h4000_0000);
        wait_idle(200, "rr");
        chk("rr_grants", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) chk("rr_order", grant_log.size() > k ? grant_log[k] : -1, exp_g[k]);
        chk("rr_res0", resp_log[0].size() > 0 ? resp_log[0][0] : 32'hDEAD_BEEF, 32'h3F80_0000);
        chk("rr_res1", resp_log[1].size() > 0 ? resp_log[1][0] : 32'hDEAD_BEEF, 32'h4000_0000);
        chk("rr_res2", resp_log[2].size() > 0 ? resp_log[2][0] : 32'hDEAD_BEEF, 32'h3F00_0000);
        chk("rr_res3", resp_log[3].size() > 0 ? resp_log[3][0] : 32'hDEAD_BEEF, 32'h4080_0000);
        chk("rr_res0b", resp_log[0].size() > 1 ? resp_log[0][1] : 32'hDEAD_BEEF, 32'h3F80_0000);

        // backpressure on requester 1
        clear_logs(); peak = 0;
        for (int v = 3; v <= 6; v++) pend_q[1].push_back(fp32_of_int(v));
        lim = 0;
        while (!(age_q.size() > 0 && age_q[0] == L) && lim < 50) begin step(); lim++; end
        resp_ready[1] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_en", 32'(exp_en), 0);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_hold", resp_data, 32'h4100_0000);
            step();
        end
        resp_ready[1] = 1'b1;
        wait_idle(100, "bp");
        chk("bp_peak", peak, 4);
        chk("bp_count", resp_log[1].size(), 4);
        for (int k = 0; k < 4; k++)
            chk("bp_data", resp_log[1].size() > k ? resp_log[1][k] : 32'hDEAD_BEEF, 32'h4100_0000 + 32'(k) * 32'h0080_0000);

        // random traffic including saturating operands
        clear_logs();
        for (int n = 0; n < 1000; n++) begin
            int r, sel;
            r = $urandom_range(0, N - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0) d = 32'h4300_0000;
            else if (sel == 1) d = 32'hC300_0000;
            else d = fp32_of_int(int'($urandom_range(0, 280)) - 140);
            pend_q[r].push_back(d);
            exp_seq[r].push_back(exp2_model(d));
        end
        rand_ready = 1'b1; rand_gap = 1'b1;
        wait_idle(20000, "rand");
        rand_ready = 1'b0; rand_gap = 1'b0; resp_ready = '1;
        for (int i = 0; i < N; i++) begin
            chk("rand_count", resp_log[i].size(), exp_seq[i].size());
            seq_bad = 0;
            for (int j = 0; j < exp_seq[i].size(); j++)
                if (j >= resp_log[i].size() || resp_log[i][j] !== exp_seq[i][j]) seq_bad++;
            chk("rand_seq", seq_bad, 0);
        end
        chk("rand_err", 32'(err), 0);

        // reset with three ops in flight
        pend_q[1].push_back(fp32_of_int(1));
        pend_q[2].push_back(fp32_of_int(2));
        pend_q[3].push_back(fp32_of_int(3));
        lim = 0;
        while (cnt < 3 && lim < 20) begin step(); lim++; end
        chk("mid_inflight_pre", 32'(inflight), 3);
        rst = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) pend_q[i].delete();
        #1;
        chk("mid_resp_valid", 32'(resp_valid), 0);
        chk("mid_inflight", 32'(inflight), 0);
        chk("mid_busy", 32'(busy), 0);
        step(); step();
        rst = 1'b0;
        clear_logs();
        pend_q[2].push_back(fp32_of_int(2));
        pend_q[0].push_back(fp32_of_int(1));
        wait_idle(100, "mid");
        chk("mid_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("mid_resp0", resp_log[0].size(), 1);
        chk("mid_resp1", resp_log[1].size(), 0);
        chk("mid_resp3", resp_log[3].size(), 0);

        // valid mismatch with empty shadow pipeline
        force_vld = 1'b1;
        step();
        force_vld = 1'b0;
        chk("mm_err_set", 32'(err), 1);
        repeat (3) step();
        chk("mm_err_held", 32'(err), 1);
        rst = 1'b1;
        #1;
        chk("mm_err_clr", 32'(err), 0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfu_exp2_arbiter.md
Name: sfu_exp2_arbiter

Overview:
- Shares one pipelined 2^x SFU unit (fp32 in, fp32 out) between NUM_REQ requesters.
- Uses round-robin arbitration and tags each issued operation.
- Routes each result back to its originator in issue order.
- Drives the unit's global enable to stall the whole pipeline when the head result's owner is not ready. Sits between the SFU request crossbar and the 2^x unit.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 32, operand/result width (fp32)
LATENCY, 6, cycles from the unit's vld_in to vld_out while en stays high
TAG_W, $clog2(NUM_REQ), requester index width
CNT_W, $clog2(LATENCY+1), in-flight counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept
req_data  in  NUM_REQ*DATA_WIDTH  packed operands; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
resp_valid  out  NUM_REQ  one-hot result valid
resp_ready  in  NUM_REQ  per-requester result accept
resp_data  out  DATA_WIDTH  result, broadcast to all requesters
exp_operand  out  DATA_WIDTH  to unit Oprand_A
exp_vld_in  out  1  to unit vld_in
exp_en  out  1  to unit en (global pipeline advance)
exp_result  in  DATA_WIDTH  from unit Result
exp_vld_out  in  1  from unit vld_out
busy  out  1  in-flight count != 0
inflight  out  CNT_W  operations issued and not yet responded
err  out  1  sticky valid-tracking mismatch

Behaviour:
- Integration: the unit's rst_n is tied to ~rst. The unit is driven only by this block.
- Shadow pipeline:
  - vld_sr[LATENCY] and tag_sr[LATENCY][TAG_W] shift by one when exp_en=1 and hold when exp_en=0.
  - Stage 0 loads exp_vld_in and the grant index.
  - The head is index LATENCY-1.
- Stall: stall = vld_sr[head] & ~resp_ready[tag_sr[head]]. exp_en = ~stall (combinational from resp_ready).
- Response:
  - resp_valid[i] = vld_sr[head] & (tag_sr[head]==i).
  - resp_data = exp_result.
  - Handshake = resp_valid[i] & resp_ready[i].
- Arbitration:
  - rr_ptr (TAG_W) holds the last granted index.
  - Grant = first asserted req_valid at indices rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[i] = exp_en & grant[i]; at most one bit is set.
  - exp_vld_in = exp_en & |req_valid.
  - exp_operand = req_data of the granted requester, or 0 when nothing is granted.
  - rr_ptr updates to the granted index only on accept (exp_vld_in=1).
- Requester rule: data must be stable while valid & ~ready. Withdrawing valid is permitted but not recommended.
- Throughput: one issue per cycle when no stall. Result appears exactly LATENCY enabled cycles after issue. Order is preserved.
- inflight counter:
  - +1 on accept, -1 on response handshake.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds LATENCY; reaching LATENCY+1 sets err.
  - busy = (inflight != 0).
- err:
  - Set when exp_en=1 and exp_vld_out != vld_sr[head], or on counter overflow/underflow.
  - Cleared only by rst.
- Stall cycle: no accept, no shift, unit frozen. The head result is held on resp_data until accepted.
- Stall release and issue in the same cycle: allowed. The head drains while a new op enters stage 0.
- Reset values (async on rst, including mid-operation):
  - vld_sr=0, tag_sr=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), inflight=0, err=0.
  - Outputs: resp_valid=0, busy=0, exp_vld_in=0; exp_en=1 (stall term is 0).
  - In-flight operations are discarded without response. The unit's own flops are reset by the same rst.

Decomposition:
- Package sfu_pkg holds:
  - SFU_DATA_W=32 and EXP2_LATENCY=6.
  - Constants FP32_ONE=32'h3F800000, FP32_INF=32'h7F800000, FP32_ZERO=32'h0.
  - typedef sfu_tag_t.
- One sub-module, rr_arbiter: parameterised NUM_REQ; inputs req and advance; output one-hot grant; holds the rr_ptr register.
- Shadow shift registers and the counter stay in the top.

Test Plan:
- Single op: req0 data 32'h3F800000 (1.0), all resp_ready=1.
  - Required: resp_valid[0] exactly 6 cycles after accept.
  - Required: resp_data=32'h40000000; inflight returns to 0.
- Round-robin: req0..3 held valid, data 0x00000000, 0x3F800000, 0xBF800000, 0x40000000.
  - Required grant order: 0,1,2,3,0.
  - Required results on resp 0..3 in order: 0x3F800000, 0x40000000, 0x3F000000, 0x40800000.
- Backpressure: 4 back-to-back ops from req1; drop resp_ready[1] for 5 cycles when the first result reaches the head.
  - Required: exp_en=0 and req_ready=0 during the stall; resp_data held.
  - Required: all 4 results arrive with no loss or duplication; inflight peaks at 4.
- Saturation: special values through random requesters: 0x43000000 (128.0) -> 0x7F800000; 0xC3000000 -> 0x00000000.
  - Required: per-requester order and tags correct over 1000 random ops with random resp_ready; err stays 0.
- Reset mid-operation: assert rst with inflight=3.
  - Required immediately: resp_valid=0, inflight=0, busy=0.
  - Required after release: first grant goes to requester 0; no stale responses.
- Mismatch: force exp_vld_out=1 with an empty shadow pipeline.
  - Required: err=1 next cycle, held until rst.
